seven_seg_scan_ctrl: RTL



---
 rtl/sevseg_pkg.sv | 34 +++
 rtl/seven_seg_scan_ctrl_bcd.sv | 35 +++
 rtl/seven_seg_scan_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sevseg_pkg.sv
// ---------------------------------------------------------------------------
// sevseg_pkg
// Shared constants for the seven-segment scan controller.
// Contents:
//   SEG_0 .. SEG_9, SEG_OFF : active-low segment codes, bit order {g,f,e,d,c,b,a}
//   state_e                 : scan FSM states
//   IDX_*                   : digit index values (0 = ones, 1 = tens, 2 = hundreds)
// ---------------------------------------------------------------------------
package sevseg_pkg;

   // Active-low segment patterns, {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0   = 7'b1000000;
   localparam logic [6:0] SEG_1   = 7'b1111001;
   localparam logic [6:0] SEG_2   = 7'b0100100;
   localparam logic [6:0] SEG_3   = 7'b0110000;
   localparam logic [6:0] SEG_4   = 7'b0011001;
   localparam logic [6:0] SEG_5   = 7'b0010010;
   localparam logic [6:0] SEG_6   = 7'b0000010;
   localparam logic [6:0] SEG_7   = 7'b1111000;
   localparam logic [6:0] SEG_8   = 7'b0000000;
   localparam logic [6:0] SEG_9   = 7'b0010000;
   localparam logic [6:0] SEG_OFF = 7'h7F;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      GAP   = 2'd2
   } state_e;

   localparam logic [1:0] IDX_ONES     = 2'd0;
   localparam logic [1:0] IDX_TENS     = 2'd1;
   localparam logic [1:0] IDX_HUNDREDS = 2'd2;

endpackage

// File: rtl/seven_seg_scan_ctrl_bcd.sv
// ---------------------------------------------------------------------------
// bin_to_bcd8
// Combinational 8-bit binary to BCD converter (shift-and-add-3).
// Ports:
//   bin      in  [7:0] : unsigned value 0..255
//   ones     out [3:0] : ones digit
//   tens     out [3:0] : tens digit
//   hundreds out [1:0] : hundreds digit (0..2)
// ---------------------------------------------------------------------------
module bin_to_bcd8 (
   input  logic [7:0] bin,
   output logic [3:0] ones,
   output logic [3:0] tens,
   output logic [1:0] hundreds
);

   logic [9:0] bcd;

   // Classic double-dabble: before each shift, any BCD nibble >= 5 gets +3
   // so that the shift carries correctly into the next decade. The hundreds
   // field never exceeds 2 for 8-bit input, so it needs no correction.
   always_comb begin
      bcd = 10'd0;
      for (int i = 0; i < 8; i++) begin
         if (bcd[3:0] >= 4'd5) bcd[3:0] = bcd[3:0] + 4'd3;
         if (bcd[7:4] >= 4'd5) bcd[7:4] = bcd[7:4] + 4'd3;
         bcd = {bcd[8:0], bin[7 - i]};
      end
   end

   assign ones     = bcd[3:0];
   assign tens     = bcd[7:4];
   assign hundreds = bcd[9:8];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_ctrl
// Time-multiplexed scan controller for a 3-digit common-anode display.
// A value taken over valid/ready sits in a pending register and is moved to
// the display register only while idle or at the end of a full frame, so a
// frame never mixes digits of two values.
// Parameters:
//   SCAN_DIV : clock cycles each digit is driven (>= 2)
// Ports:
//   clk      in       : clock, rising edge
//   rst      in       : synchronous active-high reset
//   in_valid in       : in_data valid
//   in_data  in  [7:0]: unsigned value to display
//   in_ready out      : pending register empty
//   seg      out [6:0]: segments {g..a}, active-low, registered
//   an       out [2:0]: digit enables, active-low, registered (0=ones)
// Build option:
//   SEVSEG_LZB_EN : when defined, leading zeros in hundreds/tens are blanked
// ---------------------------------------------------------------------------
module seven_seg_scan_ctrl
   import sevseg_pkg::*;
#(
   parameter int SCAN_DIV = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic [6:0] seg,
   output logic [2:0] an
);

   localparam int              DIV_W    = $clog2(SCAN_DIV + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   state_e           state_q, state_d;
   logic [7:0]       pend_q, pend_d;
   logic             pend_full_q, pend_full_d;
   logic [7:0]       disp_q, disp_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       idx_q, idx_d;
   logic [6:0]       seg_q, seg_d;
   logic [2:0]       an_q, an_d;

   logic [3:0] ones, tens, digit;
   logic [1:0] hundreds;
   logic [6:0] digit_seg;
   logic [2:0] digit_an;
   logic       blank;

   bin_to_bcd8 u_bcd (
      .bin      (disp_q),
      .ones     (ones),
      .tens     (tens),
      .hundreds (hundreds)
   );

   // Pick the digit for the current slot, decode it, and build the anode
   // pattern. Blanking only lifts the anode; slot length is untouched so
   // brightness stays the same whatever value is shown.
   always_comb begin
      case (idx_q)
         IDX_ONES: digit = ones;
         IDX_TENS: digit = tens;
         default:  digit = {2'b00, hundreds};
      endcase

      case (digit)
         4'd0:    digit_seg = SEG_0;
         4'd1:    digit_seg = SEG_1;
         4'd2:    digit_seg = SEG_2;
         4'd3:    digit_seg = SEG_3;
         4'd4:    digit_seg = SEG_4;
         4'd5:    digit_seg = SEG_5;
         4'd6:    digit_seg = SEG_6;
         4'd7:    digit_seg = SEG_7;
         4'd8:    digit_seg = SEG_8;
         4'd9:    digit_seg = SEG_9;
         default: digit_seg = SEG_OFF;
      endcase

`ifdef SEVSEG_LZB_EN
      blank = ((idx_q == IDX_HUNDREDS) && (hundreds == 2'd0)) ||
              ((idx_q == IDX_TENS) && (hundreds == 2'd0) && (tens == 4'd0));
`else
      blank = 1'b0;
`endif

      digit_an = blank ? 3'b111 : ~(3'b001 << idx_q);
   end

   // Next-state logic. The handshake and the pending->display copy can never
   // fire together: the copy needs pend_full, the handshake needs it clear.
   // seg/an are computed from the current state and registered, so the pins
   // follow the FSM by one cycle.
   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      disp_d      = disp_q;
      div_d       = div_q;
      idx_d       = idx_q;
      seg_d       = SEG_OFF;
      an_d        = 3'b111;

      if (in_valid && !pend_full_q) begin
         pend_d      = in_data;
         pend_full_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (pend_full_q) begin
               disp_d      = pend_q;
               pend_full_d = 1'b0;
               idx_d       = IDX_ONES;
               div_d       = '0;
               state_d     = DRIVE;
            end
         end
         DRIVE: begin
            seg_d = digit_seg;
            an_d  = digit_an;
            if (div_q == DIV_LAST) begin
               div_d   = '0;
               state_d = GAP;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         GAP: begin
            state_d = DRIVE;
            if (idx_q == IDX_HUNDREDS) begin
               // End of frame: the only point a new value may take effect
               idx_d = IDX_ONES;
               if (pend_full_q) begin
                  disp_d      = pend_q;
                  pend_full_d = 1'b0;
               end
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous reset; reset leaves the
   // display dark and the pending register empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         pend_q      <= 8'd0;
         pend_full_q <= 1'b0;
         disp_q      <= 8'd0;
         div_q       <= '0;
         idx_q       <= IDX_ONES;
         seg_q       <= SEG_OFF;
         an_q        <= 3'b111;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         pend_full_q <= pend_full_d;
         disp_q      <= disp_d;
         div_q       <= div_d;
         idx_q       <= idx_d;
         seg_q       <= seg_d;
         an_q        <= an_d;
      end
   end

   assign in_ready = ~pend_full_q;
   assign seg      = seg_q;
   assign an       = an_q;

endmodule
